// File: rtl/turn_sched.sv
// Round sequencer for the two-player snake game: countdown, game tick, local
// direction filtering, direction exchange over UART, step strobe, error/over handling.
module turn_sched #(
    parameter int unsigned TICK_CYCLES     = 6_500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000,
    parameter int unsigned COUNTDOWN_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] dir_local,
    input  logic [2:0] dir_rx,
    input  logic       rx_valid,
    input  logic       tx_ready,
    input  logic       game_over,
    output logic       tx_valid,
    output logic [2:0] tx_dir,
    output logic       step,
    output logic [2:0] dir1,
    output logic [2:0] dir2,
    output logic       com_err,
    output logic [2:0] state,
    output logic [1:0] countdown
);

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam int unsigned TKW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNT   = 3'd1,
        RUN     = 3'd2,
        SEND    = 3'd3,
        WAIT_RX = 3'd4,
        STEP    = 3'd5,
        OVER    = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [TKW-1:0] tk_q, tk_d;
    logic [TOW-1:0] to_q, to_d;
    logic [1:0]     cd_q, cd_d;
    logic           tx_valid_q, tx_valid_d;
    logic [2:0]     tx_dir_q, tx_dir_d;
    logic [2:0]     pend1_q, pend1_d;
    logic [2:0]     pend2_q, pend2_d;
    logic [2:0]     dir1_q, dir1_d;
    logic [2:0]     dir2_q, dir2_d;
    logic           com_err_q, com_err_d;
    logic           buf_full_q, buf_full_d;
    logic [2:0]     buf_dir_q, buf_dir_d;

    logic running, tick, overflow;

    // NONE, reversal and unknown codes all keep the previously committed direction.
    function automatic logic [2:0] filt(input logic [2:0] d, input logic [2:0] prev);
        logic opp;
        opp = (d == DIR_UP    && prev == DIR_DOWN)  || (d == DIR_DOWN  && prev == DIR_UP) ||
              (d == DIR_LEFT  && prev == DIR_RIGHT) || (d == DIR_RIGHT && prev == DIR_LEFT);
        if (d == DIR_NONE || d > DIR_RIGHT || opp) return prev;
        return d;
    endfunction

    always_comb begin
        state_d    = state_q;
        to_d       = '0;
        cd_d       = cd_q;
        tx_valid_d = tx_valid_q;
        tx_dir_d   = tx_dir_q;
        pend1_d    = pend1_q;
        pend2_d    = pend2_q;
        dir1_d     = dir1_q;
        dir2_d     = dir2_q;
        com_err_d  = com_err_q;
        buf_full_d = buf_full_q;
        buf_dir_d  = buf_dir_q;
        overflow   = 1'b0;

        running = (state_q inside {COUNT, RUN, SEND, WAIT_RX, STEP});
        tick    = running && (tk_q == TICK_LAST);

        if (rx_valid && (state_q inside {COUNT, RUN, SEND})) begin
            if (buf_full_q) begin
                com_err_d = 1'b1;
                overflow  = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_dir_d  = dir_rx;
            end
        end

        unique case (state_q)
            IDLE, OVER: begin
                tx_valid_d = 1'b0;
                if (start) begin
                    state_d    = COUNT;
                    cd_d       = 2'(COUNTDOWN_TICKS);
                    com_err_d  = 1'b0;
                    dir1_d     = DIR_UP;
                    dir2_d     = DIR_UP;
                    buf_full_d = 1'b0;
                end
            end
            COUNT: begin
                if (tick) begin
                    cd_d = cd_q - 2'd1;
                    if (cd_q == 2'd1) state_d = RUN;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (tick) begin
                    pend1_d    = filt(dir_local, dir1_q);
                    tx_dir_d   = filt(dir_local, dir1_q);
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_RX;
                end
            end
            WAIT_RX: begin
                // dir1/dir2 are committed on entry to STEP so they are valid with the strobe.
                if (buf_full_q || rx_valid) begin
                    pend2_d    = filt(buf_full_q ? buf_dir_q : dir_rx, dir2_q);
                    dir1_d     = pend1_q;
                    dir2_d     = filt(buf_full_q ? buf_dir_q : dir_rx, dir2_q);
                    buf_full_d = 1'b0;
                    state_d    = STEP;
                end else if (to_q == TO_LAST) begin
                    com_err_d = 1'b1;
                    state_d   = OVER;
                end else begin
                    to_d = to_q + TOW'(1);
                end
            end
            STEP: state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (overflow) begin
            state_d    = OVER;
            tx_valid_d = 1'b0;
        end

        if (!running || state_d == OVER || state_d == IDLE) tk_d = '0;
        else if (tick) tk_d = '0;
        else tk_d = tk_q + TKW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tk_q       <= '0;
            to_q       <= '0;
            cd_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_dir_q   <= DIR_NONE;
            pend1_q    <= DIR_UP;
            pend2_q    <= DIR_UP;
            dir1_q     <= DIR_UP;
            dir2_q     <= DIR_UP;
            com_err_q  <= 1'b0;
            buf_full_q <= 1'b0;
            buf_dir_q  <= DIR_NONE;
        end else begin
            state_q    <= state_d;
            tk_q       <= tk_d;
            to_q       <= to_d;
            cd_q       <= cd_d;
            tx_valid_q <= tx_valid_d;
            tx_dir_q   <= tx_dir_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
            com_err_q  <= com_err_d;
            buf_full_q <= buf_full_d;
            buf_dir_q  <= buf_dir_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_dir    = tx_dir_q;
    assign step      = (state_q == STEP);
    assign dir1      = dir1_q;
    assign dir2      = dir2_q;
    assign com_err   = com_err_q;
    assign state     = state_q;
    assign countdown = cd_q;

endmodule

// File: tb/tb_turn_sched.sv
// Directed bench for turn_sched: table of filter/exchange rounds plus hand-written
// countdown, early-rx, timeout, overflow, game-over and reset sequences.
module tb_turn_sched;

    localparam logic [2:0] NONE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;
    localparam logic [2:0] S_IDLE = 3'd0, S_COUNT = 3'd1, S_RUN = 3'd2, S_SEND = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4, S_STEP = 3'd5, S_OVER = 3'd6;

    logic       clk = 1'b0;
    logic       rst, start, rx_valid, tx_ready, game_over;
    logic [2:0] dir_local, dir_rx;
    logic       tx_valid, step, com_err;
    logic [2:0] tx_dir, dir1, dir2, state;
    logic [1:0] countdown;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic [2:0] loc;
        logic [2:0] rem;
        logic [2:0] exp_tx;
        logic [2:0] exp_d1;
        logic [2:0] exp_d2;
        int         ready_delay;
    } vec_t;

    vec_t vecs[8];

    turn_sched #(
        .TICK_CYCLES    (8),
        .TIMEOUT_CYCLES (20),
        .COUNTDOWN_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir_local(dir_local),
        .dir_rx   (dir_rx),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .game_over(game_over),
        .tx_valid (tx_valid),
        .tx_dir   (tx_dir),
        .step     (step),
        .dir1     (dir1),
        .dir2     (dir2),
        .com_err  (com_err),
        .state    (state),
        .countdown(countdown)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic wait_txv(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_round(input vec_t v);
        bit ok;
        dir_local = v.loc;
        tx_ready  = (v.ready_delay == 0);
        wait_txv(20, ok);
        if (!ok) begin
            check("round_txv_timeout", 0, 1);
            return;
        end
        check("round_tx_dir", tx_dir, v.exp_tx);
        for (int i = 1; i <= v.ready_delay; i++) begin
            @(negedge clk);
            check("round_txv_hold", tx_valid, 1);
            check("round_tx_dir_hold", tx_dir, v.exp_tx);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("round_txv_drop", tx_valid, 0);
        check("round_wait_state", state, S_WAIT);
        @(negedge clk);
        check("round_no_early_step", step, 0);
        rx_valid = 1'b1;
        dir_rx   = v.rem;
        @(negedge clk);
        rx_valid = 1'b0;
        check("round_step", step, 1);
        check("round_step_state", state, S_STEP);
        check("round_dir1", dir1, v.exp_d1);
        check("round_dir2", dir2, v.exp_d2);
        @(negedge clk);
        check("round_step_single", step, 0);
        check("round_back_run", state, S_RUN);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit ok;
        vecs[0] = '{DOWN,  NONE,  UP,    UP,    UP,    0};
        vecs[1] = '{NONE,  DOWN,  UP,    UP,    UP,    0};
        vecs[2] = '{LEFT,  RIGHT, LEFT,  LEFT,  RIGHT, 0};
        vecs[3] = '{RIGHT, LEFT,  LEFT,  LEFT,  RIGHT, 0};
        vecs[4] = '{UP,    UP,    UP,    UP,    UP,    0};
        vecs[5] = '{DOWN,  LEFT,  UP,    UP,    LEFT,  5};
        vecs[6] = '{RIGHT, NONE,  RIGHT, RIGHT, LEFT,  0};
        vecs[7] = '{LEFT,  DOWN,  RIGHT, RIGHT, DOWN,  0};

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; game_over = 1'b0;
        dir_local = NONE; dir_rx = NONE;
        repeat (2) @(negedge clk);
        check("rst_state", state, S_IDLE);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_dir", tx_dir, NONE);
        check("rst_step", step, 0);
        check("rst_dir1", dir1, UP);
        check("rst_dir2", dir2, UP);
        check("rst_com_err", com_err, 0);
        check("rst_countdown", countdown, 0);
        rst = 1'b0;
        @(negedge clk);

        // Countdown: 2 -> 1 -> RUN after 16 cycles; a start during COUNT is ignored.
        tx_ready = 1'b1;
        pulse_start();
        check("cnt_state", state, S_COUNT);
        check("cnt_init", countdown, 2);
        for (int n = 1; n <= 16; n++) begin
            start = (n == 3);
            @(negedge clk);
            check("cnt_no_step", step, 0);
            if (n == 7) begin
                check("cnt_before_tick1", countdown, 2);
                check("cnt_state7", state, S_COUNT);
            end
            if (n == 8) check("cnt_after_tick1", countdown, 1);
            if (n == 15) check("cnt_state15", state, S_COUNT);
            if (n == 16) begin
                check("cnt_run", state, S_RUN);
                check("cnt_zero", countdown, 0);
            end
        end
        start = 1'b0;

        for (int i = 0; i < 8; i++) run_round(vecs[i]);

        // Early rx buffered in RUN: step 3 edges after the tick.
        dir_local = DOWN;
        tx_ready  = 1'b1;
        rx_valid  = 1'b1;
        dir_rx    = LEFT;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_txv(20, ok);
        if (!ok) check("early_txv_timeout", 0, 1);
        check("early_tx_dir", tx_dir, DOWN);
        @(negedge clk);
        check("early_wait", state, S_WAIT);
        check("early_no_step", step, 0);
        @(negedge clk);
        check("early_step", step, 1);
        check("early_dir1", dir1, DOWN);
        check("early_dir2", dir2, LEFT);
        @(negedge clk);
        check("early_run", state, S_RUN);

        // Timeout: 20 cycles in WAIT_RX then OVER with com_err.
        wait_txv(20, ok);
        if (!ok) check("to_txv_timeout", 0, 1);
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            check("to_no_step", step, 0);
            if (n == 20) begin
                check("to_still_wait", state, S_WAIT);
                check("to_no_err_yet", com_err, 0);
            end
            if (n == 21) begin
                check("to_over", state, S_OVER);
                check("to_com_err", com_err, 1);
                check("to_txv", tx_valid, 0);
            end
        end
        pulse_start();
        check("restart_state", state, S_COUNT);
        check("restart_com_err", com_err, 0);
        check("restart_cd", countdown, 2);
        check("restart_dir2", dir2, UP);

        // Two rx pulses while SEND is stalled.
        tx_ready  = 1'b0;
        dir_local = LEFT;
        wait_txv(40, ok);
        if (!ok) check("ovf_txv_timeout", 0, 1);
        rx_valid = 1'b1;
        dir_rx   = UP;
        @(negedge clk);
        rx_valid = 1'b0;
        check("ovf_send", state, S_SEND);
        check("ovf_txv_held", tx_valid, 1);
        @(negedge clk);
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("ovf_over", state, S_OVER);
        check("ovf_com_err", com_err, 1);
        check("ovf_txv", tx_valid, 0);

        // game_over coinciding with the first RUN tick (cycle 23 after start).
        pulse_start();
        check("go_com_err_clr", com_err, 0);
        tx_ready = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            check("go_no_step", step, 0);
            if (n == 22) check("go_run22", state, S_RUN);
            if (n == 23) begin
                check("go_run23", state, S_RUN);
                check("go_txv23", tx_valid, 0);
            end
            if (n >= 24) begin
                check("go_over", state, S_OVER);
                check("go_txv", tx_valid, 0);
            end
            game_over = (n == 23);
        end
        game_over = 1'b0;

        // Asynchronous reset while a tx is pending.
        pulse_start();
        tx_ready  = 1'b0;
        dir_local = LEFT;
        wait_txv(40, ok);
        if (!ok) check("ar_txv_timeout", 0, 1);
        check("ar_tx_dir", tx_dir, LEFT);
        rst = 1'b1;
        #1;
        check("ar_txv", tx_valid, 0);
        check("ar_state", state, S_IDLE);
        check("ar_tx_dir_none", tx_dir, NONE);
        check("ar_cd", countdown, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_idle_hold", state, S_IDLE);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
